// File: rtl/flags_pkg.sv
// Shared types for the ALU flag consumer: condition codes, flag bit positions
// and the packed {N,Z,C,V} flags type.
package flags_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_decoder.sv
// Combinational condition-code evaluator: decides whether a condition holds
// for a given {N,Z,C,V} flag set.
module cond_decoder
  import flags_pkg::*;
(
  input  flags_t flags_i,
  input  cond_e  cond_i,
  output logic   taken_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c && !z;
      COND_LS: taken_o = !c || z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = z || (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flags_cond_unit.sv
// Consumer of ALU flags: holds the architectural flags, counts flag-setting ops
// in flight and answers condition queries once their flags are known.
module flags_cond_unit
  import flags_pkg::*;
#(
  parameter  int unsigned MAX_PENDING = 3,
  localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic          wb_valid,
  input  logic [3:0]    wb_flags,
  input  logic          flush,
  input  logic          q_valid,
  input  logic [3:0]    q_cond,
  output logic          q_ready,
  output logic          r_valid,
  output logic          r_taken,
  output logic [3:0]    flags,
  output logic [PW-1:0] pending,
  output logic          err
);

  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  flags_t        flags_q, flags_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          err_q, err_d;
  logic          r_valid_q, r_valid_d;
  logic          r_taken_q, r_taken_d;

  cond_e  cond;
  flags_t eval_flags;
  logic   wb_legal, wb_illegal;
  logic   issue_legal, issue_illegal;
  logic   accept, taken;

  assign cond = cond_e'(q_cond);

  // A flush swallows the same-cycle issue and write-back entirely.
  assign wb_legal      = wb_valid && !flush && (pending_q != '0);
  assign wb_illegal    = wb_valid && !flush && (pending_q == '0);
  assign issue_legal   = issue_valid && !flush && ((pending_q != PEND_MAX) || wb_legal);
  assign issue_illegal = issue_valid && !flush && !issue_legal;

  // Query is older than a same-cycle issue, so only older ops can stall it.
  assign q_ready = rst_n && !flush &&
                   ((cond == COND_AL) || (cond == COND_NV) ||
                    (pending_q == '0) ||
                    ((pending_q == PEND_ONE) && wb_valid));

  assign accept     = q_valid && q_ready;
  assign eval_flags = wb_legal ? flags_t'(wb_flags) : flags_q;

  cond_decoder u_cond_decoder (
    .flags_i (eval_flags),
    .cond_i  (cond),
    .taken_o (taken)
  );

  always_comb begin
    flags_d   = flags_q;
    pending_d = pending_q;
    err_d     = err_q || wb_illegal || issue_illegal;
    r_valid_d = accept;
    r_taken_d = accept && taken;

    if (wb_legal) begin
      flags_d = flags_t'(wb_flags);
    end

    if (flush) begin
      pending_d = '0;
    end else begin
      case ({issue_legal, wb_legal})
        2'b10:   pending_d = pending_q + PEND_ONE;
        2'b01:   pending_d = pending_q - PEND_ONE;
        default: pending_d = pending_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_taken_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      r_valid_q <= r_valid_d;
      r_taken_q <= r_taken_d;
    end
  end

  assign flags   = flags_q;
  assign pending = pending_q;
  assign err     = err_q;
  assign r_valid = r_valid_q;
  assign r_taken = r_taken_q;

endmodule

// File: doc/flags_cond_unit.md
# flags_cond_unit

Consumer side of the ALU flag interface: captures the 4-bit `{N,Z,C,V}` flags the ALU produces for flag-setting operations, tracks flag-setting operations in flight, and answers condition-code queries (branch / predicated execution) with a valid/ready handshake. It sits between the ALU write-back and the branch/issue logic, stalling condition queries until the flags they depend on have arrived, and forwarding same-cycle write-back flags.

## Interface
- `MAX_PENDING`, 3: maximum number of flag-setting ALU ops in flight (≥1).
- `PW`, `$clog2(MAX_PENDING+1)`: width of the pending counter (derived; do not override).

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  a flag-setting ALU op was issued this cycle.
- `wb_valid`  in  1  flags of the oldest in-flight op are on `wb_flags` this cycle.
- `wb_flags`  in  4  `{N,Z,C,V}`, same bit order as the ALU `flags` output.
- `flush`  in  1  pipeline flush; discards all in-flight ops.
- `q_valid`  in  1  condition query present.
- `q_cond`  in  4  condition code, encoding below.
- `q_ready`  out  1  query accepted this cycle when `q_valid && q_ready`.
- `r_valid`  out  1  one-cycle pulse; result of the accepted query.
- `r_taken`  out  1  condition result; meaningful only with `r_valid`.
- `flags`  out  4  architectural flags register `{N,Z,C,V}`.
- `pending`  out  PW  count of in-flight flag-setting ops.
- `err`  out  1  sticky protocol error.

## Operation
- Condition encoding: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Flags register: loads `wb_flags` on every legal `wb_valid`; otherwise holds.
- Pending counter: +1 on legal issue, −1 on legal write-back, unchanged when both occur. Never wraps.
- Illegal issue (`pending==MAX_PENDING` and no same-cycle `wb_valid`): ignored, `err` set. Illegal write-back (`pending==0`): flags not loaded, `err` set. `err` clears only on reset.
- `flush`: pending → 0 next cycle. `issue_valid` and `wb_valid` in the flush cycle are ignored, `q_ready=0`. Flags register is kept.
- `q_ready` (combinational, when not flushing and `rst_n` high): 1 if `q_cond` is AL/NV, or `pending==0`, or (`pending==1 && wb_valid`). Otherwise 0 (stall; requester holds `q_valid`/`q_cond`).
- Evaluation source: `wb_flags` when `wb_valid` is legal this cycle (forwarding), else the flags register.
- Ordering in one cycle: query is older than a same-cycle issue, so `issue_valid` never blocks the query.

## Timing
- Reset values: `flags=4'b0000`, `pending=0`, `r_valid=0`, `r_taken=0`, `err=0`. `q_ready=0` while `rst_n` low.
- Query latency: 1 cycle. Accepted in cycle t, so `r_valid=1` and `r_taken` are registered in t+1. No response backpressure; back-to-back queries give back-to-back pulses.
- Write-back visible on `flags` at t+1 and to queries in t (forwarded).
- Reset mid-query: the response is lost and `r_valid` drops immediately on assertion.

## Structure
- Package `flags_pkg`:
  - `cond_e` enum (16 codes above).
  - flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `flags_t` (logic [3:0]).
- Sub-module `cond_decoder`: combinational (`flags_t`, `cond_e`) → taken. This is the only natural split. Counter, flags register, handshake and response registers live in the top.

## Test plan
- Reset, idle, `wb_flags=4'b0100` with pending=1: query EQ accepted the same cycle, and `r_taken=1` next cycle. Query NE on the following cycle gives `r_taken=0`.
- Issue 2 ops, query GT: stalls (`q_ready=0`) through first wb `4'b1000`. At second wb `4'b0000`, `q_ready=1` and next cycle `r_taken=1`. `pending`: 2, 1, 0.
- Pending=2, query AL: accepted immediately, `r_taken=1`. Query NV the next cycle: `r_taken=0`. `pending` unchanged.
- MAX_PENDING=3: 4 issues gives `pending=3` and `err=1`. Then flush gives `pending=0`, while `flags` and `err` remain.
- `wb_valid` with pending=0, `wb_flags=4'b1111`: `flags` stays 0 and `err=1`. Simultaneous issue+wb at pending=1 keeps `pending=1`, and `flags` loads.
- Assert `rst_n=0` the cycle after a query is accepted: `r_valid=0` immediately, and all outputs are at reset values.
